// File: rtl/framebuffer_scanout_if.sv
// Framebuffer read port and DM633 serial pins driven by the scanout sequencer.
// The master side is the sequencer; the slave side is the memory and driver chain.
interface framebuffer_scanout_if #(
  parameter int c_addr_w = 10,
  parameter int c_bpc    = 12
);
  logic                o_ren;
  logic [c_addr_w-1:0] o_raddr;
  logic [c_bpc-1:0]    i_rdata;
  logic                o_dck;
  logic                o_dai;
  logic                o_lat;

  modport master (
    output o_ren,
    output o_raddr,
    input  i_rdata,
    output o_dck,
    output o_dai,
    output o_lat
  );

  modport slave (
    input  o_ren,
    input  o_raddr,
    output i_rdata,
    input  o_dck,
    input  o_dai,
    input  o_lat
  );
endinterface

// File: rtl/framebuffer_scanout.sv
// Reads one frame from the framebuffer, shifts it MSB-first into the
// daisy-chained DM633 drivers (farthest driver first), then latches it.
module framebuffer_scanout #(
  parameter int c_ledboards = 30,
  parameter int c_channels  = c_ledboards * 32,
  parameter int c_addr_w    = $clog2(c_channels),
  parameter int c_bpc       = 12,
  parameter int c_clkdiv    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  framebuffer_scanout_if.master fb
);

  localparam int c_bit_w = (c_bpc > 1) ? $clog2(c_bpc) : 1;
  localparam int c_div_w = $clog2(c_clkdiv) + 1;

  localparam logic [c_addr_w-1:0] c_addr_top =
    c_addr_w'(c_channels - 1);
  localparam logic [c_addr_w-1:0] c_addr_one =
    c_addr_w'(1);
  localparam logic [c_bit_w-1:0] c_bit_top =
    c_bit_w'(c_bpc - 1);
  localparam logic [c_bit_w-1:0] c_bit_one =
    c_bit_w'(1);
  localparam logic [c_div_w-1:0] c_div_last =
    c_div_w'(c_clkdiv - 1);
  localparam logic [c_div_w-1:0] c_div_one =
    c_div_w'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SHIFT,
    S_LATCH,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [c_addr_w-1:0] r_addr;
  logic [c_bpc-1:0]    r_sr;
  logic [c_bit_w-1:0]  r_bit;
  logic [c_div_w-1:0]  r_div;
  logic                r_ph;

  logic                r_ren;
  logic [c_addr_w-1:0] r_raddr;
  logic                r_dck;
  logic                r_dai;
  logic                r_lat;
  logic                r_busy;
  logic                r_done;

  state_t              w_state_nxt;
  logic [c_addr_w-1:0] w_addr_nxt;
  logic [c_bpc-1:0]    w_sr_nxt;
  logic [c_bit_w-1:0]  w_bit_nxt;
  logic [c_div_w-1:0]  w_div_nxt;
  logic                w_ph_nxt;
  logic                w_div_end;

  logic                w_ren_nxt;
  logic [c_addr_w-1:0] w_raddr_nxt;
  logic                w_dck_nxt;
  logic                w_dai_nxt;
  logic                w_lat_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;

  assign w_div_end = (r_div == c_div_last);

  // r_ph splits each bit (and the latch pulse) into a low and a high half,
  // each c_clkdiv cycles long as counted by r_div.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_sr_nxt    = r_sr;
    w_bit_nxt   = r_bit;
    w_div_nxt   = r_div;
    w_ph_nxt    = r_ph;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_FETCH;
          w_addr_nxt  = c_addr_top;
        end
      end
      S_FETCH: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_state_nxt = S_SHIFT;
        w_sr_nxt    = fb.i_rdata;
        w_bit_nxt   = c_bit_top;
        w_div_nxt   = '0;
        w_ph_nxt    = 1'b0;
      end
      S_SHIFT: begin
        if (!w_div_end) begin
          w_div_nxt = r_div + c_div_one;
        end else begin
          w_div_nxt = '0;
          if (!r_ph) begin
            w_ph_nxt = 1'b1;
          end else begin
            w_ph_nxt = 1'b0;
            w_sr_nxt = r_sr << 1;
            if (r_bit != '0) begin
              w_bit_nxt = r_bit - c_bit_one;
            end else if (r_addr != '0) begin
              w_addr_nxt  = r_addr - c_addr_one;
              w_state_nxt = S_FETCH;
            end else begin
              w_state_nxt = S_LATCH;
            end
          end
        end
      end
      S_LATCH: begin
        if (!w_div_end) begin
          w_div_nxt = r_div + c_div_one;
        end else begin
          w_div_nxt = '0;
          if (!r_ph) begin
            w_ph_nxt = 1'b1;
          end else begin
            w_ph_nxt    = 1'b0;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs follow the next state so they line up with the state register.
  always_comb begin
    w_ren_nxt   = (w_state_nxt == S_FETCH);
    w_raddr_nxt = w_ren_nxt ? w_addr_nxt : r_raddr;
    w_dck_nxt   = (w_state_nxt == S_SHIFT) && w_ph_nxt;
    w_dai_nxt   = (w_state_nxt == S_SHIFT) &&
                  w_sr_nxt[c_bpc-1];
    w_lat_nxt   = (w_state_nxt == S_LATCH);
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_done_nxt  = (w_state_nxt == S_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_addr  <= c_addr_top;
      r_sr    <= '0;
      r_bit   <= '0;
      r_div   <= '0;
      r_ph    <= 1'b0;
      r_ren   <= 1'b0;
      r_raddr <= '0;
      r_dck   <= 1'b0;
      r_dai   <= 1'b0;
      r_lat   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_sr    <= w_sr_nxt;
      r_bit   <= w_bit_nxt;
      r_div   <= w_div_nxt;
      r_ph    <= w_ph_nxt;
      r_ren   <= w_ren_nxt;
      r_raddr <= w_raddr_nxt;
      r_dck   <= w_dck_nxt;
      r_dai   <= w_dai_nxt;
      r_lat   <= w_lat_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign fb.o_ren   = r_ren;
  assign fb.o_raddr = r_raddr;
  assign fb.o_dck   = r_dck;
  assign fb.o_dai   = r_dai;
  assign fb.o_lat   = r_lat;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Bench for framebuffer_scanout: a 32-channel, clkdiv 1 instance and a
// default-size, clkdiv 3 instance, both checked against a frame-level model.
module tb_framebuffer_scanout;

  localparam int NA  = 32;
  localparam int AWA = 5;
  localparam int NB  = 960;
  localparam int AWB = 10;
  localparam int BPC = 12;
  localparam int CDB = 3;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic st_a = 1'b0;
  logic st_b = 1'b0;
  logic busy_a, done_a, busy_b, done_b;

  int cyc   = 0;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  framebuffer_scanout_if #(.c_addr_w(AWA), .c_bpc(BPC)) if_a();
  framebuffer_scanout_if #(.c_addr_w(AWB), .c_bpc(BPC)) if_b();

  framebuffer_scanout #(
    .c_ledboards(1),
    .c_clkdiv(1)
  ) u_a (
    .i_clk(clk),
    .i_rst(rst),
    .i_start(st_a),
    .o_busy(busy_a),
    .o_done(done_a),
    .fb(if_a.master)
  );

  framebuffer_scanout #(
    .c_ledboards(30),
    .c_clkdiv(CDB)
  ) u_b (
    .i_clk(clk),
    .i_rst(rst),
    .i_start(st_b),
    .o_busy(busy_b),
    .o_done(done_b),
    .fb(if_b.master)
  );

  logic [BPC-1:0] mem_a [NA];
  logic [BPC-1:0] mem_b [NB];

  always @(posedge clk) if (if_a.o_ren) if_a.i_rdata <= mem_a[if_a.o_raddr];
  always @(posedge clk) if (if_b.o_ren) if_b.i_rdata <= mem_b[if_b.o_raddr];

  // monitor A
  int qa_bits[$];
  int qa_ren_c[$];
  int qa_ren_a[$];
  int qa_lat[$];
  int qa_done[$];
  int a_bfall = -1;
  logic a_pdck = 1'b0;
  logic a_pbusy = 1'b0;

  always @(posedge clk) begin
    #1;
    if (if_a.o_dck && !a_pdck) qa_bits.push_back(int'(if_a.o_dai));
    if (if_a.o_ren) begin
      qa_ren_c.push_back(cyc);
      qa_ren_a.push_back(int'(if_a.o_raddr));
    end
    if (if_a.o_lat) qa_lat.push_back(cyc);
    if (done_a) qa_done.push_back(cyc);
    if (!busy_a && a_pbusy && a_bfall < 0) a_bfall = cyc;
    a_pdck  = if_a.o_dck;
    a_pbusy = busy_a;
  end

  // monitor B
  int qb_bits[$];
  int qb_lat[$];
  int qb_done[$];
  int b_run = 0;
  int b_badhi = 0;
  int b_badlo = 0;
  int b_gaps = 0;
  int b_baddai = 0;
  logic b_hiseen = 1'b0;
  logic b_pdck = 1'b0;
  logic b_pdai = 1'b0;

  always @(posedge clk) begin
    #1;
    if (if_b.o_dck && !b_pdck) qb_bits.push_back(int'(if_b.o_dai));
    if (if_b.o_dck && b_pdck && (if_b.o_dai !== b_pdai)) b_baddai++;
    if (if_b.o_lat) qb_lat.push_back(cyc);
    if (done_b) qb_done.push_back(cyc);
    if (if_b.o_dck === b_pdck) begin
      b_run++;
    end else begin
      if (b_pdck) begin
        if (b_run != CDB) b_badhi++;
        b_hiseen = 1'b1;
      end else if (b_hiseen) begin
        if (b_run == CDB + 2) b_gaps++;
        else if (b_run != CDB) b_badlo++;
      end
      b_run = 1;
    end
    if (!busy_b) b_hiseen = 1'b0;
    b_pdck = if_b.o_dck;
    b_pdai = if_b.o_dai;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic int qget(input int q[$], input int k);
    if (k < q.size()) return q[k];
    return -1;
  endfunction

  // Count words whose serial bits (MSB first) differ from the expected list.
  function automatic int bits_bad(input int q[$], input int w[$]);
    int bad = 0;
    if (q.size() < w.size() * BPC) return -1;
    for (int k = 0; k < w.size(); k++) begin
      int v = 0;
      for (int b = 0; b < BPC; b++) v = (v << 1) | (q[k*BPC + b] & 1);
      if (v != w[k]) bad++;
    end
    return bad;
  endfunction

  task automatic clr_a();
    qa_bits.delete();
    qa_ren_c.delete();
    qa_ren_a.delete();
    qa_lat.delete();
    qa_done.delete();
    a_bfall = -1;
  endtask

  int t0, t3, tb0, r, nd, nr, bad, v;
  int exp_w[$];

  initial begin
    rst  = 1'b1;
    st_a = 1'b1;
    st_b = 1'b1;
    repeat (3) begin
      tick(1);
      chk("rst_a", {busy_a, done_a, if_a.o_ren, if_a.o_raddr,
                    if_a.o_dck, if_a.o_dai, if_a.o_lat}, 64'd0);
      chk("rst_b", {busy_b, done_b, if_b.o_ren, if_b.o_raddr,
                    if_b.o_dck, if_b.o_dai, if_b.o_lat}, 64'd0);
    end
    rst  = 1'b0;
    st_a = 1'b0;
    st_b = 1'b0;
    tick(2);
    chk("ren_in_rst", qa_ren_c.size(), 0);

    // frame 1: ramp contents with a marker word at the top address
    for (int a = 0; a < NA; a++) mem_a[a] = BPC'(a);
    mem_a[NA-1] = 12'hA5C;
    exp_w.delete();
    for (int a = NA - 1; a >= 0; a--) exp_w.push_back(int'(mem_a[a]));
    clr_a();
    t0 = cyc;
    st_a = 1'b1;
    tick(1);
    st_a = 1'b0;
    tick(99);
    st_a = 1'b1;
    tick(1);
    st_a = 1'b0;
    tick(699);
    st_a = 1'b1;
    tick(36);
    chk("ren0_cyc", qget(qa_ren_c, 0), t0 + 1);
    chk("ren0_addr", qget(qa_ren_a, 0), NA - 1);
    bad = 0;
    for (int k = 0; k < NA; k++) begin
      if (qget(qa_ren_c, k) != t0 + 1 + 26*k) bad++;
      if (qget(qa_ren_a, k) != NA - 1 - k) bad++;
    end
    chk("ren_seq", bad, 0);
    v = -1;
    if (qa_bits.size() >= BPC) begin
      v = 0;
      for (int b = 0; b < BPC; b++) v = (v << 1) | (qa_bits[b] & 1);
    end
    chk("first12", v, 12'hA5C);
    chk("words_f1", bits_bad(qa_bits, exp_w), 0);
    chk("rises_f1", qa_bits.size(), NA * BPC);
    chk("lat_n", qa_lat.size(), 2);
    chk("lat0", qget(qa_lat, 0), t0 + 833);
    chk("lat1", qget(qa_lat, 1), t0 + 834);
    chk("done_n", qa_done.size(), 1);
    chk("done_cyc", qget(qa_done, 0), t0 + 835);
    chk("busy_fall", a_bfall, t0 + 836);
    tick(1);
    chk("restart_cyc", qget(qa_ren_c, NA), t0 + 837);
    chk("restart_addr", qget(qa_ren_a, NA), NA - 1);
    tick(3);
    st_a = 1'b0;

    // frame 2 started at t0+836; abort it mid-shift
    tick(296);
    rst = 1'b1;
    tick(1);
    chk("abort_dck", if_a.o_dck, 1'b0);
    chk("abort_lat", if_a.o_lat, 1'b0);
    chk("abort_busy", busy_a, 1'b0);
    rst = 1'b0;
    nd = qa_done.size();
    nr = qa_ren_c.size();
    tick(900);
    chk("abort_no_done", qa_done.size(), nd);
    chk("abort_no_ren", qa_ren_c.size(), nr);

    // frame 3: random contents, a stray start while busy
    for (int a = 0; a < NA; a++) mem_a[a] = BPC'($urandom);
    exp_w.delete();
    for (int a = NA - 1; a >= 0; a--) exp_w.push_back(int'(mem_a[a]));
    clr_a();
    t3 = cyc;
    st_a = 1'b1;
    tick(1);
    st_a = 1'b0;
    r = $urandom_range(20, 700);
    tick(r - 1);
    st_a = 1'b1;
    tick(1);
    st_a = 1'b0;
    for (int i = 0; i < 1000 && qa_done.size() == 0; i++) tick(1);
    tick(2);
    chk("f3_done", qget(qa_done, 0), t3 + 835);
    chk("f3_ren0", qget(qa_ren_a, 0), NA - 1);
    chk("f3_ren_n", qa_ren_c.size(), NA);
    chk("f3_words", bits_bad(qa_bits, exp_w), 0);
    chk("f3_rises", qa_bits.size(), NA * BPC);

    // divider 3, full-size chain
    for (int a = 0; a < NB; a++) mem_b[a] = BPC'($urandom);
    exp_w.delete();
    for (int a = NB - 1; a >= 0; a--) exp_w.push_back(int'(mem_b[a]));
    qb_bits.delete();
    qb_lat.delete();
    qb_done.delete();
    tb0 = cyc;
    st_b = 1'b1;
    tick(1);
    st_b = 1'b0;
    for (int i = 0; i < 72000 && qb_done.size() == 0; i++) tick(1);
    tick(2);
    chk("b_done", qget(qb_done, 0), tb0 + NB*74 + 7);
    chk("b_done_n", qb_done.size(), 1);
    chk("b_lat_n", qb_lat.size(), 2 * CDB);
    chk("b_lat0", qget(qb_lat, 0), tb0 + NB*74 + 1);
    chk("b_lat5", qget(qb_lat, 5), tb0 + NB*74 + 6);
    chk("b_rises", qb_bits.size(), NB * BPC);
    chk("b_words", bits_bad(qb_bits, exp_w), 0);
    chk("b_hi_len", b_badhi, 0);
    chk("b_lo_len", b_badlo, 0);
    chk("b_gaps", b_gaps, NB - 1);
    chk("b_dai_hold", b_baddai, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/framebuffer_scanout.md
# framebuffer_scanout

Sequencer that reads one complete frame out of the `framebuffer` block and shifts it serially into the daisy-chained DM633 LED drivers. It then issues the latch pulse. It owns the framebuffer read port (`o_ren`, `o_raddr`, `i_rdata`) and drives the DM633 serial pins. A frame is started by a pulse from the host-side control logic. Writes to the framebuffer during a scan are not blocked, so tearing is accepted.

## Interface

Parameters:
- `c_ledboards`, default 30: number of LED boards, each carrying two DM633 drivers.
- `c_channels`, default `c_ledboards*32`: total PWM channels, equal to the framebuffer depth.
- `c_addr_w`, default `$clog2(c_channels)`: framebuffer address width.
- `c_bpc`, default 12: bits per channel (DM633 12-bit PWM).
- `c_clkdiv`, default 2: `o_dck` half-period in `i_clk` cycles; must be ≥1.

Ports:
- `i_clk`, input, 1: the single clock; all logic is on its rising edge.
- `i_rst`, input, 1: synchronous, active-high reset.
- `i_start`, input, 1: request one frame scan; sampled only in IDLE.
- `o_busy`, output, 1: high in every state except IDLE.
- `o_done`, output, 1: single-cycle pulse when the frame is latched.
- `o_ren`, output, 1: framebuffer read enable.
- `o_raddr`, output, `c_addr_w`: framebuffer read address.
- `i_rdata`, input, `c_bpc`: framebuffer read data, valid the cycle after `o_ren`.
- `o_dck`, output, 1: DM633 serial clock.
- `o_dai`, output, 1: DM633 serial data.
- `o_lat`, output, 1: DM633 latch.

## Operation

- All outputs are registered. In reset, every output is 0, the FSM is in IDLE, and the address counter is loaded with `c_channels-1`.
- **Order:** addresses are scanned descending, `c_channels-1` down to 0, so the farthest driver's data enters first. Each word is shifted MSB first.
- **IDLE:** `o_dck`=`o_dai`=`o_lat`=0. If `i_start`=1, load address `c_channels-1` and go to FETCH.
- **FETCH** (1 cycle): `o_ren`=1 with `o_raddr`=current address. Next state is WAIT.
- **WAIT** (1 cycle): `o_ren`=0. Capture `i_rdata` into a `c_bpc`-bit shift register and load the bit counter with `c_bpc-1`. Next state is SHIFT.
- **SHIFT:** each bit lasts `2*c_clkdiv` cycles.
  - For the first `c_clkdiv` cycles, `o_dck`=0 and `o_dai`=current MSB.
  - For the next `c_clkdiv` cycles, `o_dck`=1 and `o_dai` is held.
  - After the high phase, shift left and decrement the bit counter.
- **End of word:** after the last bit's high phase:
  - If address ≠ 0, decrement the address and go to FETCH.
  - If address = 0, go to LATCH.
  - `o_dck` returns to 0 and `o_dai` to 0 outside SHIFT.
- **LATCH:** `o_lat`=1 for `2*c_clkdiv` cycles, with `o_dck`=0. Next state is DONE.
- **DONE** (1 cycle): `o_done`=1 and `o_busy`=1. Next state is IDLE.
- **`i_start` outside IDLE:** ignored, with no queuing.
- **`i_start` held high:** back-to-back frames run, with exactly one IDLE cycle between DONE and the next FETCH.
- **`i_rst` mid-operation:** aborts the scan immediately. Outputs take their reset values on the next cycle and no `o_done` is issued. The partial chain contents are left unlatched.
- **Counter widths:**
  - Address counter: `c_addr_w` bits, no wrap; the decrement from 0 never occurs.
  - Bit counter: `$clog2(c_bpc)` bits.
  - Divider: `$clog2(c_clkdiv)+1` bits.

## Timing

- If `i_start` is seen in IDLE at cycle T, FETCH occurs at T+1 with `o_raddr`=`c_channels-1`. The first `o_dai` bit is valid at T+3.
- Per word: 2 + `2*c_bpc*c_clkdiv` cycles. With defaults this is 50 cycles.
- LATCH spans `2*c_clkdiv` cycles, and `o_done` follows it.
- `o_done` cycle = T + `c_channels*(2+2*c_bpc*c_clkdiv)` + `2*c_clkdiv` + 1. With defaults this is T+48005.
- Rising edges of `o_dck` per frame: `c_channels*c_bpc`. With defaults this is 11520.
- `o_dck` duty is exactly `c_clkdiv` cycles low and `c_clkdiv` cycles high per bit. There is a 2-cycle low gap between words.

## Test plan

All scenarios use a bench memory model with 1-cycle read latency. Scenarios 2–5 use `c_ledboards`=1 (32 channels, `c_addr_w`=5) and `c_clkdiv`=1.

1. **Reset:** assert `i_rst` for 3 cycles, including while `i_start` is high → all outputs 0, `o_busy`=0, no `o_ren`.
2. **Single frame:** memory `mem[a]`=a, except `mem[31]`=12'hA5C; pulse `i_start` at T.
   - `o_ren` at T+1 with `o_raddr`=31.
   - First 12 `o_dai` values sampled on `o_dck` rises are 1010_0101_1100.
   - Reconstructed words appear in order 31..0.
3. **Frame timing:** same configuration → `o_lat` high at T+833 and T+834, `o_done` at T+835 only, exactly 384 `o_dck` rises, `o_busy` falling at T+836.
4. **Start handling:** pulse `i_start` again at T+100 → ignored, frame still completes at T+835. Then hold `i_start` high → the next FETCH occurs at T+837 (DONE at T+835, one IDLE cycle at T+836).
5. **Reset mid-shift:** assert `i_rst` at T+300 → at T+301 `o_dck`/`o_lat`/`o_busy`=0, and no `o_done` follows. A new start produces a full frame beginning at address 31.
6. **Divider:** `c_clkdiv`=3 with defaults otherwise.
   - `o_dck` is 3 cycles low then 3 cycles high per bit, and `o_dai` is stable across each high phase.
   - `o_lat` is high 6 cycles.
   - `o_done` at T + 960*74 + 7 = T+71047.
